// File: rtl/memory_cycle_pkg.sv
// Shared load/store encodings and access-size decode for the MEM stage.
package memory_cycle_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Unlisted codes fall back to a full word access.
  function automatic access_size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic access_size_e store_size(input logic [2:0] f3);
    case (f3)
      F3_B:    return SZ_BYTE;
      F3_H:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// MEM-stage inputs and MEM/WB register outputs bundled for the pipeline.
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RDM;
  logic [31:0] PCPlus4M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;

  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RDW;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, Funct3M, RDM,
           PCPlus4M, ALU_ResultM, WriteDataM,
    input  RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, Funct3M, RDM,
           PCPlus4M, ALU_ResultM, WriteDataM,
    output RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW
  );
endinterface

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data RAM with per-byte write enables and combinational read.
module data_memory #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read is sampled at the same edge that writes, so loads see pre-store data.
  assign rdata = r_mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// MEM pipeline stage: data memory access, load extension and MEM/WB register.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic           clk,
  input  logic           rst,
  memory_cycle_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] w_addr;
  logic [1:0]    w_off;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;

  assign w_addr = bus.ALU_ResultM[AW+1:2];
  assign w_off  = bus.ALU_ResultM[1:0];
  // A store presented while reset is held is discarded.
  assign w_we   = bus.MemWriteM & rst;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.WriteDataM;
    case (store_size(bus.Funct3M))
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{bus.WriteDataM[7:0]}};
      end
      SZ_HALF: begin
        w_wdata = {2{bus.WriteDataM[15:0]}};
        if (!w_off[0]) w_be = w_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (w_off == 2'b00) w_be = 4'b1111;
      end
    endcase
  end

  data_memory #(.DEPTH(DEPTH)) u_data_memory (
    .clk   (clk),
    .we    (w_we),
    .be    (w_be),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  assign w_shifted = w_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load_data = 32'h0;
    case (load_size(bus.Funct3M))
      SZ_BYTE: begin
        if (bus.Funct3M == F3_BU) w_load_data = {24'h0, w_shifted[7:0]};
        else                      w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        if (!w_off[0]) begin
          if (bus.Funct3M == F3_HU) w_load_data = {16'h0, w_shifted[15:0]};
          else                      w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      default: begin
        if (w_off == 2'b00) w_load_data = w_rdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteW   <= 1'b0;
      bus.ResultSrcW  <= 1'b0;
      bus.RDW         <= 5'd0;
      bus.PCPlus4W    <= 32'h0;
      bus.ALU_ResultW <= 32'h0;
      bus.ReadDataW   <= 32'h0;
    end else begin
      bus.RegWriteW   <= bus.RegWriteM;
      bus.ResultSrcW  <= bus.ResultSrcM;
      bus.RDW         <= bus.RDM;
      bus.PCPlus4W    <= bus.PCPlus4M;
      bus.ALU_ResultW <= bus.ALU_ResultM;
      bus.ReadDataW   <= w_load_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed plus randomized checks of memory_cycle against a byte-array model.
module tb_memory_cycle;

  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] mdl [DEPTH*4];

  memory_cycle_if bus ();

  memory_cycle #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int byte_base(input logic [31:0] a);
    return int'((a >> 2) % DEPTH) * 4 + int'(a[1:0]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    int sz;
    bit sgn;
    int base;
    logic [31:0] v;
    case (f3)
      3'b000:  begin sz = 1; sgn = 1'b1; end
      3'b001:  begin sz = 2; sgn = 1'b1; end
      3'b100:  begin sz = 1; sgn = 1'b0; end
      3'b101:  begin sz = 2; sgn = 1'b0; end
      default: begin sz = 4; sgn = 1'b0; end
    endcase
    if ((int'(a[1:0]) % sz) != 0) return 32'h0;
    base = byte_base(a);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mdl[base + i]) << (8 * i));
    if (sgn && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int sz;
    int base;
    sz = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    if ((int'(a[1:0]) % sz) != 0) return;
    base = byte_base(a);
    for (int i = 0; i < sz; i++) mdl[base + i] = d[8*i +: 8];
  endtask

  task automatic drive_idle();
    bus.RegWriteM   = 1'b0;
    bus.MemWriteM   = 1'b0;
    bus.ResultSrcM  = 1'b0;
    bus.Funct3M     = 3'b010;
    bus.RDM         = 5'd0;
    bus.PCPlus4M    = 32'h0;
    bus.ALU_ResultM = 32'h0;
    bus.WriteDataM  = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_RegWriteW"},   {31'h0, bus.RegWriteW},  32'h0);
    chk({tag, "_ResultSrcW"},  {31'h0, bus.ResultSrcW}, 32'h0);
    chk({tag, "_RDW"},         {27'h0, bus.RDW},        32'h0);
    chk({tag, "_PCPlus4W"},    bus.PCPlus4W,            32'h0);
    chk({tag, "_ALU_ResultW"}, bus.ALU_ResultW,         32'h0);
    chk({tag, "_ReadDataW"},   bus.ReadDataW,           32'h0);
  endtask

  // One instruction through MEM; W outputs checked one cycle later.
  task automatic do_op(input logic rw, input logic mw, input logic rs, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] wd, input bit chk_rd);
    logic [31:0] exp_rd;
    exp_rd = model_load(alu, f3);
    @(negedge clk);
    bus.RegWriteM   = rw;
    bus.MemWriteM   = mw;
    bus.ResultSrcM  = rs;
    bus.Funct3M     = f3;
    bus.RDM         = rd;
    bus.PCPlus4M    = pc;
    bus.ALU_ResultM = alu;
    bus.WriteDataM  = wd;
    @(posedge clk);
    #1;
    if (mw) model_store(alu, f3, wd);
    chk("RegWriteW",   {31'h0, bus.RegWriteW},  {31'h0, rw});
    chk("ResultSrcW",  {31'h0, bus.ResultSrcW}, {31'h0, rs});
    chk("RDW",         {27'h0, bus.RDW},        {27'h0, rd});
    chk("PCPlus4W",    bus.PCPlus4W,            pc);
    chk("ALU_ResultW", bus.ALU_ResultW,         alu);
    if (chk_rd) chk("ReadDataW", bus.ReadDataW, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive_idle();

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      do_op(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h0, 32'(i * 4), $urandom, 1'b0);

    do_op(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h20, 32'h10, 32'h0, 1'b1);
    chk("lw_10", bus.ReadDataW, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 1'b1, 3'b000, 5'd4, 32'h24, 32'h13, 32'h0, 1'b1);
    chk("lb_13", bus.ReadDataW, 32'hFFFFFFDE);
    do_op(1'b1, 1'b0, 1'b1, 3'b100, 5'd4, 32'h28, 32'h13, 32'h0, 1'b1);
    chk("lbu_13", bus.ReadDataW, 32'h000000DE);
    do_op(1'b1, 1'b0, 1'b1, 3'b001, 5'd5, 32'h2C, 32'h10, 32'h0, 1'b1);
    chk("lh_10", bus.ReadDataW, 32'hFFFFBEEF);
    do_op(1'b1, 1'b0, 1'b1, 3'b101, 5'd5, 32'h30, 32'h12, 32'h0, 1'b1);
    chk("lhu_12", bus.ReadDataW, 32'h0000DEAD);

    do_op(1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h34, 32'h11, 32'h55, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h38, 32'h10, 32'h0, 1'b1);
    chk("sb_11", bus.ReadDataW, 32'hDEAD55EF);
    do_op(1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h3C, 32'h11, 32'h1234, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 3'b001, 5'd6, 32'h40, 32'h11, 32'h0, 1'b1);
    chk("lh_misaligned", bus.ReadDataW, 32'h0);
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h44, 32'h10, 32'h0, 1'b1);
    chk("sh_misaligned_nowrite", bus.ReadDataW, 32'hDEAD55EF);

    do_op(1'b1, 1'b0, 1'b0, 3'b010, 5'd7, 32'h104, 32'h42, 32'h0, 1'b0);
    chk("alu_RegWriteW", {31'h0, bus.RegWriteW}, 32'h1);
    chk("alu_RDW", {27'h0, bus.RDW}, 32'd7);
    chk("alu_ALU_ResultW", bus.ALU_ResultW, 32'h42);
    chk("alu_PCPlus4W", bus.PCPlus4W, 32'h104);

    // Asynchronous reset between edges, with a store held during reset.
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    bus.MemWriteM   = 1'b1;
    bus.Funct3M     = 3'b010;
    bus.ALU_ResultM = 32'h10;
    bus.WriteDataM  = 32'h0BAD0BAD;
    @(posedge clk);
    #1;
    check_all_zero("held_reset");
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h48, 32'h10, 32'h0, 1'b1);
    chk("post_reset_mem", bus.ReadDataW, 32'hDEAD55EF);

    do_op(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h4C, 32'h10, 32'h11111111, 1'b0);
    do_op(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h50, 32'(32'h10 + 4 * DEPTH), 32'h22222222, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h54, 32'h10, 32'h0, 1'b1);
    chk("wrap", bus.ReadDataW, 32'h22222222);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4 * DEPTH - 1));
      do_op(1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 3'($urandom),
            5'($urandom), 32'($urandom), a, 32'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter DEPTH, default 1024, data memory depth in 32-bit words (power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 RegWriteM  input  1  register-file write enable of instruction in MEM.
REQ-005 MemWriteM  input  1  store enable.
REQ-006 ResultSrcM  input  1  0 = ALU result, 1 = load data.
REQ-007 Funct3M  input  3  access size/sign: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU; 000 SB, 001 SH for stores.
REQ-008 RDM  input  5  destination register index.
REQ-009 PCPlus4M, ALU_ResultM, WriteDataM  input  32 each  PC+4, effective address/ALU result, store data.
REQ-010 RegWriteW, ResultSrcW  output  1 each  registered copies for writeback.
REQ-011 RDW  output  5; PCPlus4W, ALU_ResultW, ReadDataW  output  32 each  registered copies/load data for writeback.

Function
REQ-012 Block SHALL be the MEM stage plus MEM/WB pipeline register; every output SHALL be registered, latency exactly 1 cycle from M inputs to W outputs.
REQ-013 Word index SHALL be ALU_ResultM[log2(DEPTH)+1:2]; upper address bits ignored (wrap-around modulo DEPTH words).
REQ-014 Store (MemWriteM=1) SHALL write on rising edge with byte lanes from ALU_ResultM[1:0]: SB one lane WriteDataM[7:0]; SH lanes {1:0} or {3:2} per bit1, WriteDataM[15:0]; SW all lanes.
REQ-015 Misaligned store (SH with addr[0]=1, SW with addr[1:0]!=0) SHALL write nothing.
REQ-016 Load data SHALL be read from the addressed word at the same edge, lane-selected and extended per Funct3M (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word), and registered into ReadDataW.
REQ-017 Misaligned load SHALL return ReadDataW = 0; RegWriteW still passes through unchanged.
REQ-018 Funct3 codes not listed SHALL behave as LW/SW.
REQ-019 ReadDataW SHALL be computed every cycle regardless of ResultSrcM; value meaningful only when ResultSrcW=1.
REQ-020 Read of a word being stored in the same cycle is impossible (one instruction per stage); read SHALL return pre-store contents (read-before-write).
REQ-021 Memory contents SHALL persist across cycles with MemWriteM=0.

Reset
REQ-022 rst low SHALL immediately clear RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW to 0, independent of clk.
REQ-023 Reset SHALL NOT clear data memory; a store presented in the cycle rst is asserted SHALL be dropped.
REQ-024 First edge after rst deasserts SHALL capture M inputs normally.

Structure
REQ-025 Funct3 load/store encodings SHALL live in the shared riscv package as named constants.
REQ-026 Storage, lane-enable write and raw word read SHALL be sub-module data_memory (params DEPTH; ports clk, we, byte enables[3:0], addr, wdata, rdata); extension and MEM/WB register stay in memory_cycle.

Verification
REQ-027 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ReadDataW=0xDEADBEEF one cycle after load.
REQ-028 After REQ-027: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-029 SB 0x11 data 0x55 over 0xDEADBEEF, LW 0x10 -> 0xDEAD55EF; SH 0x11 data 0x1234 -> no change, LH 0x11 -> 0.
REQ-030 Non-load RegWriteM=1, RDM=7, ALU_ResultM=0x42, PCPlus4M=0x104 -> next cycle RegWriteW=1, RDW=7, ALU_ResultW=0x42, PCPlus4W=0x104.
REQ-031 Assert rst mid-stream between edges -> all W outputs 0 without clock edge; memory still reads 0xDEAD55EF after release.
REQ-032 SW to 0x10 and to 0x10+4*DEPTH -> second overwrites first (wrap-around).
